asi_arb: RTL and testbench

// - User-side arbiter between the ASI write path (usr_wrequest/usr_wgrant) and read path (usr_rrequest/usr_rgrant).
// - Both paths share one single-port slave memory.
// - Grants a whole burst at a time: a grant is held from the request until the last beat is issued.
// - Enforces a read-to-write turnaround gap of SLV_WS cycles so that read data in flight drains first.
// - Bounds starvation of the lower-priority side.

---
 rtl/asi_arb_if.sv | 25 ++
 rtl/asi_arb.sv | 127 ++++++++++++
 tb/tb_asi_arb.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/asi_arb_if.sv
// User-side ASI arbitration bundle: per-path burst requests, issued beats, and the
// arbiter's grants and sticky error flag.
interface asi_arb_if;
    logic usr_wrequest;
    logic usr_we;
    logic usr_wlast;
    logic usr_rrequest;
    logic usr_re;
    logic usr_rlast;
    logic usr_wgrant;
    logic usr_rgrant;
    logic arb_err;

    modport slave (
        input  usr_wrequest, usr_we, usr_wlast,
        input  usr_rrequest, usr_re, usr_rlast,
        output usr_wgrant, usr_rgrant, arb_err
    );

    modport master (
        output usr_wrequest, usr_we, usr_wlast,
        output usr_rrequest, usr_re, usr_rlast,
        input  usr_wgrant, usr_rgrant, arb_err
    );
endinterface

// File: rtl/asi_arb.sv
// Burst-granular read/write arbiter for a shared single-port slave memory, with a
// read-to-write turnaround gap and a starvation guard. ASI_ARB_RR_EN selects round robin.
module asi_arb #(
    parameter int ASI_ARB    = 0,
    parameter int SLV_WS     = 1,
    parameter int ARB_STARVE = 4,
    parameter int CNTW       = 3
) (
    input  logic       usr_clk,
    input  logic       usr_reset_n,
    asi_arb_if.slave   bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WGNT = 2'd1;
    localparam logic [1:0] ST_RGNT = 2'd2;
    localparam logic [1:0] ST_TURN = 2'd3;

    localparam logic [CNTW-1:0] WS_LOAD    = CNTW'(SLV_WS);
    localparam logic [CNTW-1:0] STARVE_LIM = CNTW'(ARB_STARVE);
    localparam logic            PRIO_W     = (ASI_ARB == 0);

    logic [1:0]      state_q,  state_d;
    logic [CNTW-1:0] turn_q,   turn_d;
    logic [CNTW-1:0] starve_q, starve_d;
    logic            last_w_q, last_w_d;
    logic            wgrant_q, rgrant_q, err_q;

    logic any_req, both_req, pick_w, issue;

    always_comb begin
        any_req  = bus.usr_wrequest | bus.usr_rrequest;
        both_req = bus.usr_wrequest & bus.usr_rrequest;
`ifdef ASI_ARB_RR_EN
        pick_w = both_req ? ~last_w_q : bus.usr_wrequest;
`else
        if (both_req) begin
            pick_w = (ARB_STARVE > 0 && starve_q == STARVE_LIM) ? ~PRIO_W : PRIO_W;
        end else begin
            pick_w = bus.usr_wrequest;
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        turn_d   = turn_q;
        starve_d = starve_q;
        last_w_d = last_w_q;
        issue    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (any_req) issue = 1'b1;
            end
            ST_WGNT: begin
                if (bus.usr_we && bus.usr_wlast) begin
                    if (any_req) issue = 1'b1;
                    else         state_d = ST_IDLE;
                end
            end
            ST_RGNT: begin
                if (bus.usr_re && bus.usr_rlast) begin
                    if (!any_req) begin
                        state_d = ST_IDLE;
                    end else if (pick_w && SLV_WS > 0) begin
                        // Let in-flight read data drain before handing the bus to writes.
                        state_d = ST_TURN;
                        turn_d  = WS_LOAD;
                    end else begin
                        issue = 1'b1;
                    end
                end
            end
            default: begin
                turn_d = turn_q - CNTW'(1);
                if (turn_q <= CNTW'(1)) begin
                    if (any_req) issue = 1'b1;
                    else         state_d = ST_IDLE;
                end
            end
        endcase

        if (issue) begin
            state_d  = pick_w ? ST_WGNT : ST_RGNT;
            last_w_d = pick_w;
        end

`ifdef ASI_ARB_RR_EN
        starve_d = '0;
`else
        // Only actual grants count toward starvation, not the provisional TURN choice.
        if (issue) begin
            if (pick_w != PRIO_W) begin
                starve_d = '0;
            end else if (PRIO_W ? bus.usr_rrequest : bus.usr_wrequest) begin
                starve_d = (starve_q == '1) ? starve_q : starve_q + CNTW'(1);
            end
        end
`endif
    end

    always_ff @(posedge usr_clk or negedge usr_reset_n) begin
        if (!usr_reset_n) begin
            state_q  <= ST_IDLE;
            turn_q   <= '0;
            starve_q <= '0;
            last_w_q <= 1'b0;
            wgrant_q <= 1'b0;
            rgrant_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            turn_q   <= turn_d;
            starve_q <= starve_d;
            last_w_q <= last_w_d;
            wgrant_q <= (state_d == ST_WGNT);
            rgrant_q <= (state_d == ST_RGNT);
            err_q    <= err_q | (bus.usr_we & ~wgrant_q) | (bus.usr_re & ~rgrant_q);
        end
    end

    assign bus.usr_wgrant = wgrant_q;
    assign bus.usr_rgrant = rgrant_q;
    assign bus.arb_err    = err_q;

endmodule

// File: tb/tb_asi_arb.sv
// Directed bench for asi_arb with an owner/gap/streak model checked every cycle.
module tb_asi_arb;
    localparam int P_ASI_ARB = 0;
    localparam int P_SLV_WS  = 2;
    localparam int P_STARVE  = 2;
    localparam int P_CNTW    = 3;

    logic usr_clk = 1'b0;
    logic rst_n   = 1'b1;
    always #5 usr_clk = ~usr_clk;

    asi_arb_if ifc ();

    asi_arb #(
        .ASI_ARB(P_ASI_ARB), .SLV_WS(P_SLV_WS), .ARB_STARVE(P_STARVE), .CNTW(P_CNTW)
    ) dut (
        .usr_clk(usr_clk),
        .usr_reset_n(rst_n),
        .bus(ifc)
    );

    int total_cnt = 0;
    int pass_cnt  = 0;

    task automatic check(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // owner: 0 nobody, 1 write, 2 read. gap counts remaining turnaround cycles.
    typedef struct packed {
        logic [1:0] owner;
        int         gap;
        int         streak;
        logic [1:0] last;
        logic       err;
    } mstate_t;

    function automatic mstate_t m_reset();
        mstate_t s;
        s.owner = 2'd0; s.gap = 0; s.streak = 0; s.last = 2'd2; s.err = 1'b0;
        return s;
    endfunction

    function automatic logic [1:0] m_pick(mstate_t s, logic w, logic r);
        logic [1:0] prio, other;
        prio  = (P_ASI_ARB == 0) ? 2'd1 : 2'd2;
        other = 2'd3 - prio;
        if (!w && !r) return 2'd0;
        if (w && !r)  return 2'd1;
        if (r && !w)  return 2'd2;
`ifdef ASI_ARB_RR_EN
        return (s.last == 2'd1) ? 2'd2 : 2'd1;
`else
        if (P_STARVE > 0 && s.streak == P_STARVE) return other;
        return prio;
`endif
    endfunction

    function automatic mstate_t m_give(mstate_t s, logic [1:0] win, logic w, logic r);
        logic [1:0] prio;
        mstate_t n;
        n = s;
        prio = (P_ASI_ARB == 0) ? 2'd1 : 2'd2;
        n.owner = win;
        if (win != 2'd0) begin
            n.last = win;
`ifndef ASI_ARB_RR_EN
            if (win != prio) n.streak = 0;
            else if ((prio == 2'd1) ? r : w)
                n.streak = (s.streak + 1 > (2**P_CNTW) - 1) ? s.streak : s.streak + 1;
`endif
        end
        return n;
    endfunction

    function automatic mstate_t m_step(mstate_t s, logic w, logic we, logic wl,
                                       logic r, logic re, logic rl);
        mstate_t n;
        logic [1:0] win;
        n = s;
        n.err = s.err | (we && s.owner != 2'd1) | (re && s.owner != 2'd2);
        win = m_pick(s, w, r);
        if (s.owner == 2'd0) begin
            if (s.gap > 1) n.gap = s.gap - 1;
            else begin
                n.gap = 0;
                n = m_give(n, win, w, r);
            end
        end else if (s.owner == 2'd1) begin
            if (we && wl) n = m_give(n, win, w, r);
        end else begin
            if (re && rl) begin
                if (win == 2'd1 && P_SLV_WS > 0) begin
                    n.owner = 2'd0;
                    n.gap   = P_SLV_WS;
                end else begin
                    n = m_give(n, win, w, r);
                end
            end
        end
        return n;
    endfunction

    mstate_t m;
    always @(posedge usr_clk or negedge rst_n) begin
        if (!rst_n) m <= m_reset();
        else m <= m_step(m, ifc.usr_wrequest, ifc.usr_we, ifc.usr_wlast,
                         ifc.usr_rrequest, ifc.usr_re, ifc.usr_rlast);
    end

    always @(negedge usr_clk) begin
        if (rst_n) begin
            check("cyc_wgrant", int'(ifc.usr_wgrant), int'(m.owner == 2'd1));
            check("cyc_rgrant", int'(ifc.usr_rgrant), int'(m.owner == 2'd2));
            check("cyc_err",    int'(ifc.arb_err),    int'(m.err));
        end
    end

    task automatic step1();
        @(posedge usr_clk);
        #1;
    endtask

    task automatic clr_beats();
        ifc.usr_we = 0; ifc.usr_wlast = 0; ifc.usr_re = 0; ifc.usr_rlast = 0;
    endtask

    logic [1:0] order [6];
    logic [1:0] exp_order [6];

    initial begin
        ifc.usr_wrequest = 0; ifc.usr_rrequest = 0;
        clr_beats();
`ifdef ASI_ARB_RR_EN
        exp_order = '{2'd2, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1};
`else
        exp_order = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd2};
`endif
        #2 rst_n = 0;
        #1;
        check("rst_wgrant", int'(ifc.usr_wgrant), 0);
        check("rst_rgrant", int'(ifc.usr_rgrant), 0);
        check("rst_err",    int'(ifc.arb_err),    0);
        repeat (2) @(posedge usr_clk);
        #3 rst_n = 1;
        step1();
        check("idle_wgrant", int'(ifc.usr_wgrant), 0);

        // Both request: write wins, then read follows with no bubble.
        ifc.usr_wrequest = 1; ifc.usr_rrequest = 1;
        step1();
        check("both_wgrant", int'(ifc.usr_wgrant), 1);
        check("both_rgrant", int'(ifc.usr_rgrant), 0);
        ifc.usr_wlast = 1;              // unqualified last must be ignored
        step1();
        check("wlast_only_hold", int'(ifc.usr_wgrant), 1);
        ifc.usr_wrequest = 0; ifc.usr_we = 1; ifc.usr_wlast = 1;
        step1();
        clr_beats();
        check("w2r_rgrant", int'(ifc.usr_rgrant), 1);
        check("w2r_wgrant", int'(ifc.usr_wgrant), 0);
        ifc.usr_rrequest = 0;
        repeat (2) step1();             // request dropped, grant must persist
        check("r_hold", int'(ifc.usr_rgrant), 1);
        ifc.usr_re = 1; ifc.usr_rlast = 1;
        step1();
        clr_beats();
        check("r_end_idle", int'(ifc.usr_rgrant), 0);

        // Read-to-write turnaround of two cycles.
        ifc.usr_rrequest = 1;
        step1();
        check("gap_rgrant", int'(ifc.usr_rgrant), 1);
        ifc.usr_rrequest = 0; ifc.usr_wrequest = 1; ifc.usr_re = 1; ifc.usr_rlast = 1;
        step1();
        clr_beats();
        check("gap1_w", int'(ifc.usr_wgrant), 0);
        check("gap1_r", int'(ifc.usr_rgrant), 0);
        step1();
        check("gap2_w", int'(ifc.usr_wgrant), 0);
        check("gap2_r", int'(ifc.usr_rgrant), 0);
        step1();
        check("gap_end_w", int'(ifc.usr_wgrant), 1);
        ifc.usr_wrequest = 0; ifc.usr_we = 1; ifc.usr_wlast = 1;
        step1();
        clr_beats();
        step1();

        // Continuous contention: record the burst owner sequence.
        ifc.usr_wrequest = 1; ifc.usr_rrequest = 1;
        for (int b = 0; b < 6; b++) begin
            int t;
            t = 0;
            while (!(ifc.usr_wgrant || ifc.usr_rgrant) && t < 20) begin
                step1();
                t++;
            end
            check("grant_timeout", int'(t < 20), 1);
            order[b] = ifc.usr_wgrant ? 2'd1 : 2'd2;
            if (order[b] == 2'd1) ifc.usr_we = 1; else ifc.usr_re = 1;
            step1();
            if (b == 5) begin ifc.usr_wrequest = 0; ifc.usr_rrequest = 0; end
            if (order[b] == 2'd1) ifc.usr_wlast = 1; else ifc.usr_rlast = 1;
            step1();
            clr_beats();
        end
        for (int b = 0; b < 6; b++) check($sformatf("order%0d", b), int'(order[b]), int'(exp_order[b]));
        repeat (2) step1();
        check("pre_err", int'(ifc.arb_err), 0);

        // Read beat without a grant latches the error.
        ifc.usr_re = 1;
        step1();
        clr_beats();
        check("err_set", int'(ifc.arb_err), 1);
        repeat (3) step1();
        check("err_sticky", int'(ifc.arb_err), 1);

        // Asynchronous reset in the middle of a write burst.
        ifc.usr_wrequest = 1;
        step1();
        check("prerst_wgrant", int'(ifc.usr_wgrant), 1);
        #2 rst_n = 0;
        #1;
        check("async_wgrant", int'(ifc.usr_wgrant), 0);
        check("async_err",    int'(ifc.arb_err),    0);
        @(posedge usr_clk);
        #3 rst_n = 1;
        step1();
        check("postrst_wgrant", int'(ifc.usr_wgrant), 1);
        ifc.usr_wrequest = 0; ifc.usr_we = 1; ifc.usr_wlast = 1;
        step1();
        clr_beats();
        check("final_idle", int'(ifc.usr_wgrant), 0);
        repeat (2) step1();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
